// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and the IF/ID register,
// with an instruction-memory handshake and stall/flush/redirect handling.
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 stall_IFID,
    input  logic                 flush_IFID,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] instr_IFID,
    output logic [WORD_SIZE-1:0] pc_plus1_IFID,
    output logic                 valid_IFID,
    output logic                 fetch_busy
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, SQUASH} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] buf_q, buf_d;
    logic [WORD_SIZE-1:0] target_q, target_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [WORD_SIZE-1:0] pcp1_q, pcp1_d;
    logic                 valid_q, valid_d;
    logic                 accept, load, busy;
    logic [WORD_SIZE-1:0] pc_inc, load_word;

    assign accept    = ir_write & pc_write & !stall_IFID & !flush_IFID & !redirect_valid;
    assign pc_inc    = pc_q + WORD_SIZE'(1);
    assign load      = accept & (((state_q == REQ) & i_ready) | (state_q == HOLD));
    assign load_word = (state_q == HOLD) ? buf_q : i_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            target_q <= '0;
            instr_q  <= '0;
            pcp1_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            target_q <= target_d;
            instr_q  <= instr_d;
            pcp1_q   <= pcp1_d;
            valid_q  <= valid_d;
        end
    end

    // An outstanding request cannot be cancelled, so a redirect without a
    // response parks in SQUASH and the newest target wins.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_d    = redirect_valid ? redirect_pc : pc_q;
            end
            REQ: begin
                if (redirect_valid) begin
                    if (i_ready) pc_d = redirect_pc;
                    else begin
                        target_d = redirect_pc;
                        state_d  = SQUASH;
                    end
                end else if (i_ready) begin
                    if (accept) pc_d = pc_inc;
                    else begin
                        buf_d   = i_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    buf_d   = '0;
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (accept) begin
                    pc_d    = pc_inc;
                    state_d = REQ;
                end
            end
            SQUASH: begin
                target_d = redirect_valid ? redirect_pc : target_q;
                if (i_ready) begin
                    pc_d    = target_d;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // When ID consumes (ir_write, no stall) but nothing arrives, a bubble is
    // inserted so the same instruction is never issued twice.
    always_comb begin
        instr_d = instr_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        if (flush_IFID) valid_d = 1'b0;
        else if (load) begin
            instr_d = load_word;
            pcp1_d  = pc_inc;
            valid_d = 1'b1;
        end else if (ir_write & !stall_IFID) valid_d = 1'b0;
    end

    always_comb begin
        busy = (state_q == REQ) || (state_q == SQUASH);
    end

    assign i_readM       = busy;
    assign fetch_busy    = busy;
    assign i_address     = pc_q;
    assign instr_IFID    = instr_q;
    assign pc_plus1_IFID = pcp1_q;
    assign valid_IFID    = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a zero-wait memory
// model and manually driven responses for latency and redirect cases.
module tb_fetch_unit;
    logic        clk, reset, pc_write, ir_write, stall_IFID, flush_IFID, redirect_valid;
    logic [15:0] redirect_pc, i_address, i_data, instr_IFID, pc_plus1_IFID;
    logic        i_readM, i_ready, valid_IFID, fetch_busy;
    logic        auto_mem, man_ready;
    logic [15:0] man_data;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign i_ready = auto_mem ? i_readM : man_ready;
    assign i_data  = auto_mem ? mem(i_address) : man_data;

    fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .ir_write(ir_write),
        .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .instr_IFID(instr_IFID), .pc_plus1_IFID(pc_plus1_IFID),
        .valid_IFID(valid_IFID), .fetch_busy(fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (i_readM !== 1'b0) $display("FAIL reset i_readM got %b want 0", i_readM); else passes++;
        checks++; if (i_address !== 16'h0000) $display("FAIL reset i_address got %h want 0000", i_address); else passes++;
        checks++; if (instr_IFID !== 16'h0000) $display("FAIL reset instr got %h want 0000", instr_IFID); else passes++;
        checks++; if (pc_plus1_IFID !== 16'h0000) $display("FAIL reset pc_plus1 got %h want 0000", pc_plus1_IFID); else passes++;
        checks++; if (valid_IFID !== 1'b0) $display("FAIL reset valid got %b want 0", valid_IFID); else passes++;
        checks++; if (fetch_busy !== 1'b0) $display("FAIL reset busy got %b want 0", fetch_busy); else passes++;
        reset = 1'b0;
        checks++; if (i_readM !== 1'b0) $display("FAIL idle i_readM got %b want 0", i_readM); else passes++;
    endtask

    task automatic test_zero_wait();
        step();
        checks++; if (i_readM !== 1'b1) $display("FAIL first_req i_readM got %b want 1", i_readM); else passes++;
        checks++; if (i_address !== 16'h0000) $display("FAIL first_req addr got %h want 0000", i_address); else passes++;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (i_address !== 16'(k)) $display("FAIL zw%0d addr got %h want %h", k, i_address, 16'(k)); else passes++;
            checks++; if (instr_IFID !== mem(16'(k - 1))) $display("FAIL zw%0d instr got %h want %h", k, instr_IFID, mem(16'(k - 1))); else passes++;
            checks++; if (pc_plus1_IFID !== 16'(k)) $display("FAIL zw%0d pc_plus1 got %h want %h", k, pc_plus1_IFID, 16'(k)); else passes++;
            checks++; if (valid_IFID !== 1'b1) $display("FAIL zw%0d valid got %b want 1", k, valid_IFID); else passes++;
        end
    endtask

    task automatic test_stall_hold();
        auto_mem = 1'b0; man_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0004;
        step();
        checks++; if (i_address !== 16'h0004) $display("FAIL redir4 addr got %h want 0004", i_address); else passes++;
        redirect_valid = 1'b0; auto_mem = 1'b1;
        step();
        checks++; if (pc_plus1_IFID !== 16'h0005) $display("FAIL pre_stall pc_plus1 got %h want 0005", pc_plus1_IFID); else passes++;
        checks++; if (i_address !== 16'h0005) $display("FAIL pre_stall addr got %h want 0005", i_address); else passes++;
        auto_mem = 1'b0; man_ready = 1'b1; man_data = 16'h1234;
        stall_IFID = 1'b1; pc_write = 1'b0; ir_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            man_ready = 1'b0;
            checks++; if (i_readM !== 1'b0) $display("FAIL hold%0d i_readM got %b want 0", k, i_readM); else passes++;
            checks++; if (fetch_busy !== 1'b0) $display("FAIL hold%0d busy got %b want 0", k, fetch_busy); else passes++;
            checks++; if (i_address !== 16'h0005) $display("FAIL hold%0d addr got %h want 0005", k, i_address); else passes++;
            checks++; if (instr_IFID !== mem(16'h0004)) $display("FAIL hold%0d instr got %h want %h", k, instr_IFID, mem(16'h0004)); else passes++;
            checks++; if (pc_plus1_IFID !== 16'h0005 || valid_IFID !== 1'b1) $display("FAIL hold%0d ifid got %h/%b want 0005/1", k, pc_plus1_IFID, valid_IFID); else passes++;
        end
        stall_IFID = 1'b0; pc_write = 1'b1; ir_write = 1'b1; auto_mem = 1'b1;
        step();
        checks++; if (instr_IFID !== 16'h1234) $display("FAIL release instr got %h want 1234", instr_IFID); else passes++;
        checks++; if (pc_plus1_IFID !== 16'h0006) $display("FAIL release pc_plus1 got %h want 0006", pc_plus1_IFID); else passes++;
        checks++; if (valid_IFID !== 1'b1) $display("FAIL release valid got %b want 1", valid_IFID); else passes++;
        checks++; if (i_address !== 16'h0006 || i_readM !== 1'b1) $display("FAIL release req got %h/%b want 0006/1", i_address, i_readM); else passes++;
    endtask

    task automatic test_redirect_flush();
        auto_mem = 1'b0; man_ready = 1'b0;
        step();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0006) $display("FAIL wait req got %b/%h want 1/0006", i_readM, i_address); else passes++;
        redirect_valid = 1'b1; redirect_pc = 16'h0040; flush_IFID = 1'b1;
        step();
        checks++; if (fetch_busy !== 1'b1 || i_address !== 16'h0006) $display("FAIL squash got %b/%h want 1/0006", fetch_busy, i_address); else passes++;
        checks++; if (valid_IFID !== 1'b0) $display("FAIL flush valid got %b want 0", valid_IFID); else passes++;
        redirect_valid = 1'b0; flush_IFID = 1'b0; man_ready = 1'b1; man_data = 16'hDEAD;
        step();
        man_ready = 1'b0;
        checks++; if (i_address !== 16'h0040) $display("FAIL redir40 addr got %h want 0040", i_address); else passes++;
        checks++; if (valid_IFID !== 1'b0) $display("FAIL redir40 valid got %b want 0", valid_IFID); else passes++;
        checks++; if (instr_IFID === 16'hDEAD) $display("FAIL redir40 instr got %h want not dead", instr_IFID); else passes++;
    endtask

    task automatic test_double_redirect();
        man_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0010; flush_IFID = 1'b1;
        step();
        checks++; if (i_address !== 16'h0010) $display("FAIL dr_setup addr got %h want 0010", i_address); else passes++;
        man_ready = 1'b0; redirect_pc = 16'h0040; flush_IFID = 1'b0;
        step();
        checks++; if (i_address !== 16'h0010 || fetch_busy !== 1'b1) $display("FAIL dr_first got %h/%b want 0010/1", i_address, fetch_busy); else passes++;
        redirect_pc = 16'h0080;
        step();
        checks++; if (i_address !== 16'h0010 || i_readM !== 1'b1) $display("FAIL dr_second got %h/%b want 0010/1", i_address, i_readM); else passes++;
        redirect_valid = 1'b0; man_ready = 1'b1; man_data = 16'hBEEF;
        step();
        checks++; if (i_address !== 16'h0080) $display("FAIL dr_target addr got %h want 0080", i_address); else passes++;
        checks++; if (valid_IFID !== 1'b0) $display("FAIL dr_target valid got %b want 0", valid_IFID); else passes++;
        auto_mem = 1'b1;
        step();
        checks++; if (instr_IFID !== mem(16'h0080)) $display("FAIL dr_load instr got %h want %h", instr_IFID, mem(16'h0080)); else passes++;
        checks++; if (pc_plus1_IFID !== 16'h0081 || valid_IFID !== 1'b1) $display("FAIL dr_load ifid got %h/%b want 0081/1", pc_plus1_IFID, valid_IFID); else passes++;
    endtask

    task automatic test_wrap();
        auto_mem = 1'b0; man_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        step();
        checks++; if (i_address !== 16'hFFFF) $display("FAIL wrap_setup addr got %h want ffff", i_address); else passes++;
        redirect_valid = 1'b0; auto_mem = 1'b1;
        step();
        checks++; if (pc_plus1_IFID !== 16'h0000) $display("FAIL wrap pc_plus1 got %h want 0000", pc_plus1_IFID); else passes++;
        checks++; if (i_address !== 16'h0000) $display("FAIL wrap addr got %h want 0000", i_address); else passes++;
        checks++; if (instr_IFID !== mem(16'hFFFF) || valid_IFID !== 1'b1) $display("FAIL wrap instr got %h/%b want %h/1", instr_IFID, valid_IFID, mem(16'hFFFF)); else passes++;
    endtask

    task automatic test_reset_squash();
        auto_mem = 1'b0; man_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0200;
        step();
        checks++; if (fetch_busy !== 1'b1 || i_address !== 16'h0000) $display("FAIL rs_squash got %b/%h want 1/0000", fetch_busy, i_address); else passes++;
        redirect_valid = 1'b0; man_ready = 1'b1; man_data = 16'h5555; reset = 1'b1;
        #1;
        checks++; if (i_readM !== 1'b0 || valid_IFID !== 1'b0) $display("FAIL rs_async got %b/%b want 0/0", i_readM, valid_IFID); else passes++;
        step();
        checks++; if (i_readM !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL rs_edge req got %b/%b want 0/0", i_readM, fetch_busy); else passes++;
        checks++; if (i_address !== 16'h0000) $display("FAIL rs_edge addr got %h want 0000", i_address); else passes++;
        checks++; if (instr_IFID !== 16'h0000 || pc_plus1_IFID !== 16'h0000 || valid_IFID !== 1'b0) $display("FAIL rs_edge ifid got %h/%h/%b want 0000/0000/0", instr_IFID, pc_plus1_IFID, valid_IFID); else passes++;
        reset = 1'b0; man_ready = 1'b0;
        step();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) $display("FAIL rs_restart got %b/%h want 1/0000", i_readM, i_address); else passes++;
        checks++; if (valid_IFID !== 1'b0) $display("FAIL rs_restart valid got %b want 0", valid_IFID); else passes++;
    endtask

    initial begin
        reset = 1'b1; pc_write = 1'b1; ir_write = 1'b1; stall_IFID = 1'b0; flush_IFID = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; auto_mem = 1'b1; man_ready = 1'b0; man_data = '0;
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_redirect_flush();
        test_double_redirect();
        test_wrap();
        test_reset_squash();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined TSC CPU. It sits between instruction memory and the ID stage. It owns the PC and the IF/ID pipeline register, and it carries out the stall, flush and redirect commands that the hazard control logic issues. It runs a request/response handshake with instruction memory and holds or discards fetched words so that no instruction is lost or duplicated across stalls and mispredictions.

## Interface
Parameters:
- WORD_SIZE, 16, width of instructions, PC and addresses
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- pc_write  input  1  hazard control: PC may advance this cycle
- ir_write  input  1  hazard control: IF/ID register may load this cycle
- stall_IFID  input  1  hazard control: hold IF/ID contents
- flush_IFID  input  1  hazard control: invalidate IF/ID contents
- redirect_valid  input  1  misprediction (jump or branch) resolved; fetch must restart at redirect_pc
- redirect_pc  input  WORD_SIZE  correct next PC, sampled when redirect_valid=1
- i_readM  output  1  instruction-memory read request
- i_address  output  WORD_SIZE  request address, equal to PC
- i_data  input  WORD_SIZE  instruction word, valid when i_ready=1
- i_ready  input  1  memory response strobe; one cycle per request
- instr_IFID  output  WORD_SIZE  IF/ID instruction
- pc_plus1_IFID  output  WORD_SIZE  IF/ID fetch PC + 1
- valid_IFID  output  1  IF/ID holds a real instruction; 0 means bubble
- fetch_busy  output  1  1 when a memory request is outstanding (state REQ or SQUASH)

## Operation
- accept = ir_write & pc_write & !stall_IFID & !flush_IFID & !redirect_valid.
- State IDLE is the reset state. i_readM=0. On the next edge, unconditionally go to REQ.
- State REQ:
  - i_readM=1, i_address=PC.
  - Address stays stable until i_ready.
  - On i_ready with accept: load IF/ID with {i_data, PC+1, valid=1}, PC <= PC+1, stay in REQ.
  - On i_ready without accept and without redirect: store i_data in the hold buffer and go to HOLD. PC is unchanged.
- State HOLD:
  - i_readM=0.
  - On accept: load IF/ID from the buffer, PC <= PC+1, go to REQ.
- Redirect (redirect_valid=1):
  - In IDLE or HOLD: discard the buffer, PC <= redirect_pc, go to REQ.
  - In REQ with i_ready=1: discard i_data, PC <= redirect_pc, stay in REQ.
  - In REQ with i_ready=0: the request cannot be cancelled. Latch redirect_pc into the target register and go to SQUASH.
- State SQUASH:
  - i_readM=1, address unchanged.
  - On i_ready: discard i_data, PC <= target, go to REQ.
  - A second redirect while in SQUASH overwrites the target. The newest redirect wins.
- flush_IFID=1: valid_IFID <= 0 on the next edge. Flush takes priority over stall and over load.
- stall_IFID=1 without flush: the IF/ID register holds all fields.
- Priority in one cycle: reset > redirect > flush > stall > accept.
- PC arithmetic is modulo 2^WORD_SIZE. 16'hFFFF + 1 wraps to 16'h0000.

## Timing
- Reset values:
  - PC=RESET_PC, state=IDLE
  - i_readM=0, i_address=RESET_PC
  - instr_IFID=0, pc_plus1_IFID=0, valid_IFID=0
  - fetch_busy=0, hold buffer=0, target=0
- Reset asserted mid-request returns to IDLE immediately. The outstanding memory response after reset is ignored, because i_ready is only looked at in REQ/SQUASH and the first request is issued after IDLE.
- First request is asserted in the first cycle after reset deassertion plus one edge (IDLE -> REQ).
- Zero-wait memory (i_ready in the same cycle as i_readM): one instruction per cycle. The IF/ID register updates on the edge that ends the i_ready cycle.
- Redirect latency: the redirected address appears on i_address in the cycle after the redirect edge. With a response outstanding, it appears in the cycle after i_ready.
- Stall with the word already held (HOLD): zero added latency on release. IF/ID loads on the first edge where accept=1.
- i_readM, i_address and fetch_busy are functions of state and PC only, with no input-to-output combinational path.

## Test plan
- Reset then zero-wait memory returning PC-indexed words -> i_address goes 0,1,2,3 on consecutive cycles; instr_IFID follows one edge later with valid_IFID=1 and pc_plus1_IFID=1,2,3.
- stall_IFID=1 with pc_write=ir_write=0 for 3 cycles while i_ready=1 returns word 0x1234 at PC=5 -> state HOLD, IF/ID unchanged, i_readM=0. On release, IF/ID gets 0x1234 with pc_plus1_IFID=6, then i_address=6.
- 2-cycle-latency memory, redirect_valid with redirect_pc=0x0040 and flush_IFID in the cycle before i_ready -> returning word discarded, valid_IFID=0, next i_address=0x0040.
- Two redirects (0x0040, then 0x0080) during one outstanding request -> only 0x0080 fetched; no instruction from 0x0040 or from the old PC reaches IF/ID.
- PC=16'hFFFF accepted -> pc_plus1_IFID=0, next i_address=0.
- reset pulsed in SQUASH with i_ready=1 on the same cycle -> all outputs at reset values, PC=RESET_PC, the response is not loaded.
